// File: rtl/fft_agu_pkg.sv
// Shared definitions for the FFT sequencer / address-generation unit.
//   state_t / ST_*  : FSM state encoding (IDLE, LOAD, RUN, DRAIN, UNLOAD)
//   clog2()         : ceiling log2 for parameter arithmetic
//   digitsum()      : sum of the radix digits of a value (bank selection)
//   insert_digit()  : open a digit slot in a value and place a lane index there
package fft_agu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_RUN    = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_UNLOAD = 3'd4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Sum of the ndig low digits of value, each digit log_r bits wide.
    function automatic int digitsum(input logic [31:0] value, input int log_r, input int ndig);
        int          sum;
        logic [31:0] mask;
        sum  = 0;
        mask = (32'd1 << log_r) - 32'd1;
        for (int i = 0; i < ndig; i++) begin
            sum += int'((value >> (i * log_r)) & mask);
        end
        return sum;
    endfunction

    // Digits of value at positions >= pos move up one digit; digit is placed at pos.
    function automatic logic [31:0] insert_digit(input logic [31:0] value, input logic [31:0] digit,
                                                 input int pos, input int log_r);
        logic [31:0] low_mask;
        int          sh;
        sh       = pos * log_r;
        low_mask = (32'd1 << sh) - 32'd1;
        return ((value & ~low_mask) << log_r) | (digit << sh) | (value & low_mask);
    endfunction

endpackage

// File: rtl/fft_addr_map.sv
// Combinational address map for one butterfly group / one load-unload row.
//   c    : word counter within the current phase
//   s    : current stage (only meaningful when mode = 1)
//   mode : 1 = butterfly (RUN) addressing, 0 = linear load/unload addressing
//   addr : per-bank row addresses, bank b at [b*ADDR_W +: ADDR_W]
//   rot  : rotation between bank order and lane order, digitsum(c) mod LANES
module fft_addr_map
    import fft_agu_pkg::*;
#(
    parameter int   LOG_R  = 4,
    parameter int   STAGES = 4,
    localparam int  LANES  = 1 << LOG_R,
    localparam int  ADDR_W = LOG_R * (STAGES - 1),
    localparam int  SW     = clog2(STAGES + 1)
) (
    input  logic [ADDR_W-1:0]       c,
    input  logic [SW-1:0]           s,
    input  logic                    mode,
    output logic [LANES*ADDR_W-1:0] addr,
    output logic [LOG_R-1:0]        rot
);

    int pos;

    // The skew of every point in a group equals digitsum(c) plus its lane index,
    // so the group's banks are a rotation of the lane order by digitsum(c).
    assign rot = LOG_R'(digitsum(32'(c), LOG_R, STAGES - 1));

    // Stage s combines the points that differ only in digit STAGES-1-s.
    assign pos = (int'(s) < STAGES) ? (STAGES - 1 - int'(s)) : 0;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
        logic [LOG_R-1:0]  lane;
        logic [ADDR_W-1:0] run_addr;

        // Lane served by this bank; the row drops the low digit of the point.
        assign lane     = LOG_R'(gi) - rot;
        assign run_addr = ADDR_W'(insert_digit(32'(c), 32'(lane), pos, LOG_R) >> LOG_R);
        assign addr[gi*ADDR_W +: ADDR_W] = mode ? run_addr : c;
    end

endmodule

// File: rtl/fft_seq_agu.sv
// Sequencer and address generator for the memory-based radix-LANES FFT core.
// Walks LOAD -> (RUN, DRAIN) x STAGES -> UNLOAD, ping-ponging between bank
// set A (IO buffer) and B (scratch), with skewed conflict-free banking.
//   CLK, RSTn       : clock, synchronous active-low reset
//   START           : run request, honoured in IDLE only
//   BUSY, DONE      : activity flag, one-cycle completion pulse
//   STAGE           : stage index (STAGES during LOAD/UNLOAD) for the twiddle ROM
//   WE_A, WE_B      : bank-set write enables
//   SEL_RD          : read bank set (0 = A, 1 = B)
//   RD_ADDR/WR_ADDR : per-bank addresses, bank b at [b*ADDR_W +: ADDR_W]
//   ROT_RD/ROT_WR   : rotation amounts for the read/write networks
//   OUT_VALID       : unload read data valid
module fft_seq_agu
    import fft_agu_pkg::*;
#(
    parameter int   LOG_R    = 4,
    parameter int   STAGES   = 4,
    parameter int   PIPE_LAT = 8,
    localparam int  LANES    = 1 << LOG_R,
    localparam int  ADDR_W   = LOG_R * (STAGES - 1),
    localparam int  SW       = clog2(STAGES + 1)
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [SW-1:0]           STAGE,
    output logic                    WE_A,
    output logic                    WE_B,
    output logic                    SEL_RD,
    output logic [LANES*ADDR_W-1:0] RD_ADDR,
    output logic [LANES*ADDR_W-1:0] WR_ADDR,
    output logic [LOG_R-1:0]        ROT_RD,
    output logic [LOG_R-1:0]        ROT_WR,
    output logic                    OUT_VALID
);

    localparam int   WORDS     = 1 << ADDR_W;
    localparam int   CNT_W     = (ADDR_W + 1 > clog2(PIPE_LAT) + 1) ? ADDR_W + 1 : clog2(PIPE_LAT) + 1;
    localparam int   E_W       = 2 + LOG_R + LANES * ADDR_W;
    // The last stage writes B when its index is even, i.e. when STAGES is odd.
    localparam logic FINAL_SET = 1'(STAGES % 2);

    state_t             state_reg, state_next;
    logic [SW-1:0]      stage_reg, stage_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               out_valid_reg;

    logic               in_load, in_run, unload_rd, reading;
    logic [LANES*ADDR_W-1:0] map_addr;
    logic [LOG_R-1:0]   map_rot;

    // Write-side delay line: {valid, dest set, rotation, addresses}.
    logic [PIPE_LAT-1:0][E_W-1:0] pipe_reg;
    logic [E_W-1:0]               entry_in;
    logic                         tail_valid, tail_dest;
    logic [LOG_R-1:0]             tail_rot;
    logic [LANES*ADDR_W-1:0]      tail_addr;

    assign in_load   = (state_reg == ST_LOAD);
    assign in_run    = (state_reg == ST_RUN);
    // UNLOAD holds one extra cycle (cnt == WORDS) to present the last word and DONE.
    assign unload_rd = (state_reg == ST_UNLOAD) && (cnt_reg < CNT_W'(WORDS));
    assign reading   = in_run | unload_rd;

    fft_addr_map #(
        .LOG_R  (LOG_R),
        .STAGES (STAGES)
    ) u_addr_map (
        .c    (cnt_reg[ADDR_W-1:0]),
        .s    (stage_reg),
        .mode (in_run),
        .addr (map_addr),
        .rot  (map_rot)
    );

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (START) begin
                    state_next = ST_LOAD;
                    stage_next = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_reg == CNT_W'(WORDS - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_reg == CNT_W'(WORDS - 1)) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == CNT_W'(PIPE_LAT - 1)) begin
                    cnt_next = '0;
                    if (stage_reg == SW'(STAGES - 1)) begin
                        state_next = ST_UNLOAD;
                    end else begin
                        state_next = ST_RUN;
                        stage_next = stage_reg + SW'(1);
                    end
                end
            end
            ST_UNLOAD: begin
                if (cnt_reg == CNT_W'(WORDS)) begin
                    state_next = ST_IDLE;
                    stage_next = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                stage_next = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg     <= ST_IDLE;
            stage_reg     <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= unload_rd;
        end
    end

    // Every RUN read is echoed as a write PIPE_LAT cycles later into the other set.
    assign entry_in = in_run ? {1'b1, ~stage_reg[0], map_rot, map_addr} : '0;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= entry_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign tail_valid = pipe_reg[PIPE_LAT-1][E_W-1];
    assign tail_dest  = pipe_reg[PIPE_LAT-1][E_W-2];
    assign tail_rot   = pipe_reg[PIPE_LAT-1][E_W-3 -: LOG_R];
    assign tail_addr  = pipe_reg[PIPE_LAT-1][LANES*ADDR_W-1:0];

    always_comb begin
        STAGE = '0;
        case (state_reg)
            ST_LOAD, ST_UNLOAD: STAGE = SW'(STAGES);
            ST_RUN, ST_DRAIN:   STAGE = stage_reg;
            default:            STAGE = '0;
        endcase
    end

    assign BUSY      = (state_reg != ST_IDLE);
    assign DONE      = (state_reg == ST_UNLOAD) && (cnt_reg == CNT_W'(WORDS));
    // LOAD never overlaps a pipeline write, so the two sources of WE_A are exclusive.
    assign WE_A      = in_load | (tail_valid & ~tail_dest);
    assign WE_B      = tail_valid & tail_dest;
    assign SEL_RD    = in_run ? stage_reg[0] : (unload_rd & FINAL_SET);
    assign RD_ADDR   = reading ? map_addr : '0;
    assign ROT_RD    = reading ? map_rot : '0;
    // In LOAD the map runs in linear mode, giving WR_ADDR = c and ROT_WR = digitsum(c).
    assign WR_ADDR   = in_load ? map_addr : tail_addr;
    assign ROT_WR    = in_load ? map_rot : tail_rot;
    assign OUT_VALID = out_valid_reg;

endmodule

// File: tb/tb_fft_seq_agu.sv
// Self-checking bench for fft_seq_agu with LOG_R=2, STAGES=3, PIPE_LAT=8
// (WORDS=16, T=105). Expected outputs come from a schedule model computed
// with plain arithmetic on point digits, plus a per-stage read/write scoreboard.
module tb_fft_seq_agu;

    localparam int LR    = 2;
    localparam int ST    = 3;
    localparam int PL    = 8;
    localparam int LANES = 4;
    localparam int AW    = 4;
    localparam int SW    = 2;
    localparam int WORDS = 16;
    localparam int SLOT  = WORDS + PL;
    localparam int T     = WORDS * (ST + 2) + ST * PL + 1;

    logic                  clk;
    logic                  rstn;
    logic                  start;
    logic                  busy, done, we_a, we_b, sel_rd, out_valid;
    logic [SW-1:0]         stage;
    logic [LANES*AW-1:0]   rd_addr, wr_addr;
    logic [LR-1:0]         rot_rd, rot_wr;

    int total;
    int bad;
    int rd_cnt [WORDS*LANES];
    int wr_cnt [WORDS*LANES];

    typedef struct {
        logic                busy, done, we_a, we_b, sel_rd, ov;
        int                  stage, rot_rd, rot_wr;
        logic [LANES*AW-1:0] rd, wr;
    } exp_t;

    fft_seq_agu #(
        .LOG_R    (LR),
        .STAGES   (ST),
        .PIPE_LAT (PL)
    ) dut (
        .CLK       (clk),
        .RSTn      (rstn),
        .START     (start),
        .BUSY      (busy),
        .DONE      (done),
        .STAGE     (stage),
        .WE_A      (we_a),
        .WE_B      (we_b),
        .SEL_RD    (sel_rd),
        .RD_ADDR   (rd_addr),
        .WR_ADDR   (wr_addr),
        .ROT_RD    (rot_rd),
        .ROT_WR    (rot_wr),
        .OUT_VALID (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dsum(input int v, input int nd);
        int r;
        r = 0;
        for (int i = 0; i < nd; i++) begin
            r += v % LANES;
            v  = v / LANES;
        end
        return r;
    endfunction

    function automatic int ins(input int c, input int l, input int pos);
        int m;
        m = 1;
        for (int i = 0; i < pos; i++) m *= LANES;
        return (c / m) * m * LANES + l * m + c % m;
    endfunction

    // Addresses of butterfly group c in stage s, placed at Bank(p) = digitsum(p) mod LANES.
    function automatic logic [LANES*AW-1:0] group_addr(input int s, input int c);
        logic [LANES*AW-1:0] v;
        int p, b;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            p = ins(c, l, ST - 1 - s);
            b = dsum(p, ST) % LANES;
            v[b*AW +: AW] = AW'(p / LANES);
        end
        return v;
    endfunction

    function automatic logic [LANES*AW-1:0] flat_addr(input int c);
        logic [LANES*AW-1:0] v;
        v = '0;
        for (int b = 0; b < LANES; b++) v[b*AW +: AW] = AW'(c);
        return v;
    endfunction

    // Expected outputs k cycles after START was sampled (k = 0: idle).
    function automatic exp_t model(input int k);
        exp_t e;
        int rel, s, c;
        e = '{busy: 1'b0, done: 1'b0, we_a: 1'b0, we_b: 1'b0, sel_rd: 1'b0, ov: 1'b0,
              stage: 0, rot_rd: 0, rot_wr: 0, rd: '0, wr: '0};
        if (k >= 1 && k <= T) begin
            e.busy = 1'b1;
            if (k <= WORDS) begin
                c        = k - 1;
                e.stage  = ST;
                e.we_a   = 1'b1;
                e.wr     = flat_addr(c);
                e.rot_wr = dsum(c, ST - 1) % LANES;
            end else if (k <= WORDS + ST * SLOT) begin
                rel     = k - WORDS - 1;
                s       = rel / SLOT;
                c       = rel % SLOT;
                e.stage = s;
                if (c < WORDS) begin
                    e.sel_rd = 1'(s % 2);
                    e.rd     = group_addr(s, c);
                    e.rot_rd = dsum(c, ST - 1) % LANES;
                end
                if (c >= PL && c < PL + WORDS) begin
                    e.wr     = group_addr(s, c - PL);
                    e.rot_wr = dsum(c - PL, ST - 1) % LANES;
                    if (s % 2 == 0) e.we_b = 1'b1;
                    else            e.we_a = 1'b1;
                end
            end else begin
                c       = k - (WORDS + ST * SLOT) - 1;
                e.stage = ST;
                if (c < WORDS) begin
                    e.sel_rd = 1'(ST % 2);
                    e.rd     = flat_addr(c);
                    e.rot_rd = dsum(c, ST - 1) % LANES;
                end
                if (c >= 1)     e.ov   = 1'b1;
                if (c == WORDS) e.done = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Point held by bank b at the given row: its low digit completes the bank skew.
    function automatic int point_of(input int b, input int row);
        return row * LANES + ((b - dsum(row, ST - 1)) % LANES + LANES) % LANES;
    endfunction

    task automatic check_cycle(input int k);
        exp_t e;
        int rel, c, nr, nw;
        e = model(k);
        chk("busy",    k, 64'(busy),      64'(e.busy));
        chk("done",    k, 64'(done),      64'(e.done));
        chk("stage",   k, 64'(stage),     64'(e.stage));
        chk("we_a",    k, 64'(we_a),      64'(e.we_a));
        chk("we_b",    k, 64'(we_b),      64'(e.we_b));
        chk("sel_rd",  k, 64'(sel_rd),    64'(e.sel_rd));
        chk("rd_addr", k, 64'(rd_addr),   64'(e.rd));
        chk("wr_addr", k, 64'(wr_addr),   64'(e.wr));
        chk("rot_rd",  k, 64'(rot_rd),    64'(e.rot_rd));
        chk("rot_wr",  k, 64'(rot_wr),    64'(e.rot_wr));
        chk("out_vld", k, 64'(out_valid), 64'(e.ov));
        if (k > WORDS && k <= WORDS + ST * SLOT) begin
            rel = k - WORDS - 1;
            c   = rel % SLOT;
            if (c == 0) begin
                for (int p = 0; p < WORDS * LANES; p++) begin
                    rd_cnt[p] = 0;
                    wr_cnt[p] = 0;
                end
            end
            for (int b = 0; b < LANES; b++) begin
                if (c < WORDS) rd_cnt[point_of(b, int'(rd_addr[b*AW +: AW]))]++;
                if (we_a === 1'b1 || we_b === 1'b1) wr_cnt[point_of(b, int'(wr_addr[b*AW +: AW]))]++;
            end
            if (c == SLOT - 1) begin
                nr = 0;
                nw = 0;
                for (int p = 0; p < WORDS * LANES; p++) begin
                    if (rd_cnt[p] != 1) nr++;
                    if (wr_cnt[p] != 1) nw++;
                end
                chk("rd_once", k, 64'(nr), 64'(0));
                chk("wr_once", k, 64'(nw), 64'(0));
            end
        end
    endtask

    // Called in the cycle where START is already high in IDLE (cycle 0).
    // mode 0: START dropped, 1: START held, 2: START random during the run.
    task automatic do_run(input int mode, input logic next_start);
        int ov_seen;
        ov_seen = 0;
        for (int k = 1; k <= T; k++) begin
            @(posedge clk);
            #1;
            case (mode)
                0:       start = 1'b0;
                1:       start = 1'b1;
                default: start = 1'($urandom_range(0, 1));
            endcase
            check_cycle(k);
            if (out_valid === 1'b1) ov_seen++;
        end
        chk("ov_count", T, 64'(ov_seen), 64'(WORDS));
        @(posedge clk);
        #1;
        start = next_start;
        check_cycle(0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_cycle(0);
        end
    endtask

    initial begin
        int rk;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_cycle(0);

        // Plain pulse after a random idle gap.
        idle_cycles($urandom_range(1, 4));
        start = 1'b1;
        do_run(0, 1'b0);
        idle_cycles(2);

        // START held high: the run ignores it, then a second run starts from IDLE.
        start = 1'b1;
        do_run(1, 1'b1);
        do_run(1, 1'b0);
        idle_cycles(3);

        // START toggled randomly during a run: only one DONE, no restart.
        start = 1'b1;
        do_run(2, 1'b0);
        idle_cycles(3);

        // One-cycle reset inside the stage-1 drain.
        start = 1'b1;
        rk = $urandom_range(WORDS + SLOT + WORDS + 1, WORDS + 2 * SLOT);
        for (int k = 1; k <= rk; k++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom_range(0, 1));
            check_cycle(k);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        start = 1'b0;
        check_cycle(0);
        idle_cycles(2);

        // Normal run after the reset.
        start = 1'b1;
        do_run(0, 1'b0);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
